// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths, exception vector
// and the fetch-queue entry type.
package if_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned EXC_VECTOR = 112;
   localparam int unsigned FQ_DEPTH   = 4;
   localparam int unsigned FQ_PTR_W   = $clog2(FQ_DEPTH);
   localparam int unsigned FQ_CNT_W   = FQ_PTR_W + 1;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc_plus4;
   } fq_entry_t;

endpackage

// File: rtl/if_fq_fifo.sv
// Fetch queue: DEPTH-entry circular buffer of fq_entry_t with push, pop, flush and an
// occupancy count. Head reads as zero while empty.
module if_fq_fifo
   import if_pkg::*;
#(
   parameter int unsigned DEPTH = FQ_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    flush,
   input  fq_entry_t               wr_entry,
   output fq_entry_t               head,
   output logic                    empty,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PW = $clog2(DEPTH);

   fq_entry_t       mem [DEPTH];
   logic [PW-1:0]   rd_ptr_q;
   logic [PW-1:0]   wr_ptr_q;
   logic [PW:0]     cnt_q;
   logic            do_push;
   logic            do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (PW+1)'(DEPTH));
   assign count   = cnt_q;
   assign do_pop  = pop && !flush && !empty;
   // A full queue still accepts a push when the head leaves in the same cycle.
   assign do_push = push && !flush && (!full || do_pop);
   assign head    = empty ? '0 : mem[rd_ptr_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wr_entry;
   end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC, loadable instruction array, redirect/flush priority and a
// fetch queue toward decode. Define IF_FQ_BYPASS_EN for the zero-latency empty-queue path.
module if_fetch_queue #(
   parameter int unsigned     XLEN       = if_pkg::XLEN,
   parameter int unsigned     IMEM_DEPTH = 32,
   parameter int unsigned     FQ_DEPTH   = if_pkg::FQ_DEPTH,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(if_pkg::EXC_VECTOR)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          imem_wr_en,
   input  logic [$clog2(IMEM_DEPTH)-1:0] imem_wr_addr,
   input  logic [XLEN-1:0]               imem_wr_data,
   input  logic                          redirect_vld,
   input  logic [XLEN-1:0]               redirect_pc,
   input  logic                          exc_flush,
   input  logic                          id_ready,
   output logic                          id_valid,
   output logic [XLEN-1:0]               id_instr,
   output logic [XLEN-1:0]               id_pc_plus4,
   output logic [$clog2(FQ_DEPTH):0]     fq_count
);

   import if_pkg::*;

   localparam int unsigned IW = $clog2(IMEM_DEPTH);

   logic [XLEN-1:0] imem [IMEM_DEPTH];
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] fetch_instr;
   logic [XLEN-1:0] fetch_pc_plus4;
   logic            kill;
   logic            bypass;
   logic            pop;
   logic            push;
   logic            fq_empty;
   logic            fq_full;
   logic            unused_redirect_lsbs;
   fq_entry_t       wr_entry;
   fq_entry_t       head;

   assign fetch_instr    = imem[pc_q[2 +: IW]];
   assign fetch_pc_plus4 = pc_q + XLEN'(4);
   assign kill           = exc_flush | redirect_vld;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

`ifdef IF_FQ_BYPASS_EN
   // The fetched word goes straight to decode and is never written into the queue.
   assign bypass = fq_empty & ~kill & id_ready & ~rst;
`else
   assign bypass = 1'b0;
`endif

   // A flush or redirect discards any pop; decode drops the word it saw that cycle.
   assign pop      = ~fq_empty & id_ready & ~kill;
   assign push     = ~kill & ~bypass & (~fq_full | pop);
   assign wr_entry = '{instr: fetch_instr, pc_plus4: fetch_pc_plus4};

   if_fq_fifo #(
      .DEPTH (FQ_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .flush    (kill),
      .wr_entry (wr_entry),
      .head     (head),
      .empty    (fq_empty),
      .full     (fq_full),
      .count    (fq_count)
   );

   always_comb begin
      id_valid    = ~fq_empty;
      id_instr    = head.instr;
      id_pc_plus4 = head.pc_plus4;
      if (bypass) begin
         id_valid    = 1'b1;
         id_instr    = fetch_instr;
         id_pc_plus4 = fetch_pc_plus4;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else if (exc_flush) begin
         pc_q <= EXC_VECTOR;
      end else if (redirect_vld) begin
         pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (push || bypass) begin
         pc_q <= fetch_pc_plus4;
      end
   end

   // Array contents survive reset; a same-cycle fetch of the written index sees the old word.
   always_ff @(posedge clk) begin
      if (imem_wr_en) imem[imem_wr_addr] <= imem_wr_data;
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: stimulus loads expected words into a scoreboard queue,
// a negedge monitor checks every accepted handshake, and directed checks cover the corners.
module tb_if_fetch_queue;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned IMEM_DEPTH = 32;
   localparam int unsigned FQ_DEPTH   = 4;

   logic                          clk = 1'b0;
   logic                          rst;
   logic                          imem_wr_en;
   logic [$clog2(IMEM_DEPTH)-1:0] imem_wr_addr;
   logic [XLEN-1:0]               imem_wr_data;
   logic                          redirect_vld;
   logic [XLEN-1:0]               redirect_pc;
   logic                          exc_flush;
   logic                          id_ready;
   logic                          id_valid;
   logic [XLEN-1:0]               id_instr;
   logic [XLEN-1:0]               id_pc_plus4;
   logic [$clog2(FQ_DEPTH):0]     fq_count;

   if_fetch_queue #(
      .XLEN       (XLEN),
      .IMEM_DEPTH (IMEM_DEPTH),
      .FQ_DEPTH   (FQ_DEPTH),
      .RESET_PC   (32'h0),
      .EXC_VECTOR (32'd112)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_wr_en   (imem_wr_en),
      .imem_wr_addr (imem_wr_addr),
      .imem_wr_data (imem_wr_data),
      .redirect_vld (redirect_vld),
      .redirect_pc  (redirect_pc),
      .exc_flush    (exc_flush),
      .id_ready     (id_ready),
      .id_valid     (id_valid),
      .id_instr     (id_instr),
      .id_pc_plus4  (id_pc_plus4),
      .fq_count     (fq_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_plus4;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // Program image: word i holds 0x1000_0000 + i; the fetch index wraps at IMEM_DEPTH.
   function automatic logic [31:0] word_at(input logic [31:0] pc);
      return 32'h1000_0000 + ((pc >> 2) % IMEM_DEPTH);
   endfunction

   task automatic start_stream(input logic [31:0] pc, input int n);
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{instr: word_at(pc + 32'(4 * i)), pc_plus4: pc + 32'(4 * i + 4)});
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every accepted transfer must be the next expected word.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && id_valid && id_ready && !exc_flush && !redirect_vld) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got instr 0x%0h with no expected entry", id_instr);
         end else begin
            e = exp_q.pop_front();
            check("sb_instr", 64'(id_instr), 64'(e.instr));
            check("sb_pc_plus4", 64'(id_pc_plus4), 64'(e.pc_plus4));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst          = 1'b1;
      imem_wr_en   = 1'b0;
      imem_wr_addr = '0;
      imem_wr_data = '0;
      redirect_vld = 1'b0;
      redirect_pc  = '0;
      exc_flush    = 1'b0;
      id_ready     = 1'b0;

      @(posedge clk); #1;
      check("rst_valid", 64'(id_valid), 64'd0);
      check("rst_instr", 64'(id_instr), 64'd0);
      check("rst_pc_plus4", 64'(id_pc_plus4), 64'd0);
      check("rst_count", 64'(fq_count), 64'd0);

      for (int i = 0; i < 32; i++) begin
         imem_wr_en   = 1'b1;
         imem_wr_addr = 5'(i);
         imem_wr_data = 32'h1000_0000 + 32'(i);
         @(posedge clk); #1;
      end

      // Release with decode stalled: first word appears one cycle after the first fetch.
      imem_wr_en = 1'b0;
      rst        = 1'b0;
      start_stream(32'h0, 64);
      #1;
      check("t1_valid_pre", 64'(id_valid), 64'd0);
      check("t1_count_pre", 64'(fq_count), 64'd0);
      @(posedge clk); #2;
      check("t1_valid", 64'(id_valid), 64'd1);
      check("t1_instr", 64'(id_instr), 64'h1000_0000);
      check("t1_pc_plus4", 64'(id_pc_plus4), 64'd4);
      check("t1_count", 64'(fq_count), 64'd1);

      repeat (9) @(posedge clk);
      #2;
      check("t2_count_sat", 64'(fq_count), 64'd4);
      check("t2_pc_stop", 64'(dut.pc_q), 64'd16);

      // Full queue with decode ready: push and pop every cycle, pc crosses 128.
      id_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #2;
         check("t5_count_full", 64'(fq_count), 64'd4);
      end

      // Exception beats redirect in the same cycle.
      exc_flush    = 1'b1;
      redirect_vld = 1'b1;
      redirect_pc  = 32'h40;
      start_stream(32'd112, 64);
      @(posedge clk); #2;
      exc_flush    = 1'b0;
      redirect_vld = 1'b0;
      id_ready     = 1'b0;
      #1;
      check("t4_count", 64'(fq_count), 64'd0);
      check("t4_valid", 64'(id_valid), 64'd0);
      check("t4_pc", 64'(dut.pc_q), 64'd112);
      repeat (3) @(posedge clk);
      #2;
      check("t4_count3", 64'(fq_count), 64'd3);
      check("t4_instr", 64'(id_instr), 64'h1000_001C);
      check("t4_pc_plus4", 64'(id_pc_plus4), 64'h74);

      // Redirect to an unaligned target with 3 queued and a pop request in the same cycle.
      id_ready     = 1'b1;
      redirect_vld = 1'b1;
      redirect_pc  = 32'h2B;
      start_stream(32'h28, 64);
      @(posedge clk); #2;
      redirect_vld = 1'b0;
      id_ready     = 1'b0;
      #1;
      check("t3_count", 64'(fq_count), 64'd0);
      check("t3_valid", 64'(id_valid), 64'd0);
      check("t3_pc", 64'(dut.pc_q), 64'h28);
      @(posedge clk); #2;
      check("t3_instr", 64'(id_instr), 64'h1000_000A);
      check("t3_pc_plus4", 64'(id_pc_plus4), 64'h2C);
      check("t3_count1", 64'(fq_count), 64'd1);
      id_ready = 1'b1;
      repeat (12) @(posedge clk);
      #2;

      // Asynchronous reset mid-stream.
      rst = 1'b1;
      #1;
      check("t6_rst_valid", 64'(id_valid), 64'd0);
      check("t6_rst_instr", 64'(id_instr), 64'd0);
      check("t6_rst_pc_plus4", 64'(id_pc_plus4), 64'd0);
      check("t6_rst_count", 64'(fq_count), 64'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      start_stream(32'h0, 64);
      #1;
`ifdef IF_FQ_BYPASS_EN
      check("t6_bypass_valid", 64'(id_valid), 64'd1);
      check("t6_bypass_instr", 64'(id_instr), 64'h1000_0000);
`else
      check("t6_valid_pre", 64'(id_valid), 64'd0);
`endif
      @(posedge clk); #2;
      check("t6_valid", 64'(id_valid), 64'd1);
      repeat (10) @(posedge clk);
      #2;
      id_ready = 1'b0;
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
